hilo_sequencer: RTL and testbench

//  Sequences the multicycle divider and multiplier for MULT/DIV instructions.

---
 rtl/hilo_if.sv | 21 ++
 rtl/hilo_sequencer.sv | 114 +++++++++++
 tb/tb_hilo_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hilo_if.sv
// hilo_if: CPU-side MULT/DIV request and HI/LO result bus of hilo_sequencer.
interface hilo_if;
    logic        start;
    logic        op;
    logic        is_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (
        output start, op, is_signed, src_a, src_b,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, is_signed, src_a, src_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/hilo_sequencer.sv
// hilo_sequencer: issues MULT/DIV to the multicycle units, stalls the CPU and captures HI/LO.
// Define MULDIV_SIGNED_EN for signed ops (magnitudes to the units, sign fix at capture).
module hilo_sequencer #(
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    hilo_if.slave       bus,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        div_init,
    output logic        mult_init,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, CAPTURE, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             op_r;
    logic             accept;
    logic             reject;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [31:0]      cap_hi;
    logic [31:0]      cap_lo;
    logic [63:0]      raw;
    assign accept = (state == IDLE || state == DONE) && bus.start;
    assign reject = bus.op && bus.src_b == 32'd0;
    assign last   = op_r ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    assign raw    = op_r ? {div_hi, div_lo} : {mult_hi, mult_lo};
`ifdef MULDIV_SIGNED_EN
    logic        neg_a;
    logic        neg_b;
    logic        sa_r;
    logic        sb_r;
    logic [63:0] prod;
    assign neg_a  = bus.is_signed && bus.src_a[31];
    assign neg_b  = bus.is_signed && bus.src_b[31];
    assign mag_a  = neg_a ? -bus.src_a : bus.src_a;
    assign mag_b  = neg_b ? -bus.src_b : bus.src_b;
    assign prod   = (sa_r ^ sb_r) ? -raw : raw;
    // remainder follows the dividend, quotient follows the sign product
    assign cap_hi = op_r ? (sa_r ? -div_hi : div_hi) : prod[63:32];
    assign cap_lo = op_r ? ((sa_r ^ sb_r) ? -div_lo : div_lo) : prod[31:0];
    always_ff @(posedge clk or posedge reset)
        if (reset)
            {sa_r, sb_r} <= 2'b00;
        else if (accept && !reject)
            {sa_r, sb_r} <= {neg_a, neg_b};
`else
    assign mag_a            = bus.src_a;
    assign mag_b            = bus.src_b;
    assign {cap_hi, cap_lo} = raw;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_r         <= 1'b0;
            unit_a       <= 32'd0;
            unit_b       <= 32'd0;
            div_init     <= 1'b0;
            mult_init    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= 32'd0;
            bus.lo       <= 32'd0;
        end else begin
            div_init     <= 1'b0;
            mult_init    <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept && reject)
                        bus.div_zero <= 1'b1;
                    else if (accept) begin
                        state     <= INIT;
                        op_r      <= bus.op;
                        unit_a    <= mag_a;
                        unit_b    <= mag_b;
                        div_init  <= bus.op;
                        mult_init <= !bus.op;
                        bus.busy  <= 1'b1;
                    end
                end
                INIT: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == last)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.hi   <= cap_hi;
                    bus.lo   <= cap_lo;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer: directed MULT/DIV vectors with hand-computed HI/LO and timing.
module tb_hilo_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] unit_a, unit_b, div_hi, div_lo, mult_hi, mult_lo;
    logic        div_init, mult_init;
    int          n_checks = 0;
    int          n_fail = 0;
    int          dones, busy_n, dinit_n, minit_n, zero_n, zero_at, done_at, multi;
    logic [31:0] hi_d, lo_d;

    hilo_if bus();

    hilo_sequencer dut (
        .clk(clk), .reset(reset), .bus(bus),
        .unit_a(unit_a), .unit_b(unit_b),
        .div_init(div_init), .mult_init(mult_init),
        .div_hi(div_hi), .div_lo(div_lo),
        .mult_hi(mult_hi), .mult_lo(mult_lo)
    );

    always #5 clk = ~clk;

    // behavioural units: results settle long before capture
    assign div_hi = unit_b == 32'd0 ? 32'd0 : unit_a % unit_b;
    assign div_lo = unit_b == 32'd0 ? 32'd0 : unit_a / unit_b;
    assign {mult_hi, mult_lo} = {32'd0, unit_a} * {32'd0, unit_b};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = o; bus.is_signed = s; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic watch(input int n);
        dones = 0; busy_n = 0; dinit_n = 0; minit_n = 0; zero_n = 0;
        zero_at = 0; done_at = 0; multi = 0; hi_d = 'x; lo_d = 'x;
        for (int k = 1; k <= n; k++) begin
            busy_n  += int'(bus.busy);
            dinit_n += int'(div_init);
            minit_n += int'(mult_init);
            if (int'(bus.done) + int'(bus.div_zero) + int'(div_init) + int'(mult_init) > 1) multi++;
            if (bus.div_zero) begin
                zero_n++;
                if (zero_at == 0) zero_at = k;
            end
            if (bus.done) begin
                dones++;
                if (done_at == 0) begin done_at = k; hi_d = bus.hi; lo_d = bus.lo; end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int t;
        bus.start = 1'b0; bus.op = 1'b0; bus.is_signed = 1'b0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_hilo", {bus.hi, bus.lo}, 0);
        check("rst_unit", {unit_a, unit_b}, 0);
        check("rst_pulses", {bus.done, bus.div_zero, div_init, mult_init}, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        check("div_unit_a", unit_a, 100);
        check("div_unit_b", unit_b, 7);
        watch(40);
        check("div_done_at", done_at, 35);
        check("div_busy_n", busy_n, 34);
        check("div_init_n", dinit_n, 1);
        check("div_minit_n", minit_n, 0);
        check("div_dones", dones, 1);
        check("div_excl", multi, 0);
        check("div_hi", hi_d, 2);
        check("div_lo", lo_d, 14);

        issue(1'b1, 1'b0, 32'd5, 32'd0);
        watch(5);
        check("dz_at", zero_at, 1);
        check("dz_n", zero_n, 1);
        check("dz_busy", busy_n, 0);
        check("dz_init", dinit_n + minit_n, 0);
        check("dz_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        watch(40);
        check("mul_done_at", done_at, 35);
        check("mul_minit_n", minit_n, 1);
        check("mul_dinit_n", dinit_n, 0);
        check("mul_hilo", {hi_d, lo_d}, 64'h0000_0001_FFFF_FFFE);

        issue(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.src_a = 32'd50; bus.src_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        watch(40);
        check("ign_dones", dones, 1);
        check("ign_zero", zero_n, 0);
        check("ign_hilo", {hi_d, lo_d}, 64'd15);

        issue(1'b0, 1'b0, 32'd6, 32'd7);
        t = 0;
        while (!bus.done && t < 60) begin @(negedge clk); t++; end
        check("b2b_done_seen", bus.done, 1);
        check("b2b_first", {bus.hi, bus.lo}, 64'd42);
        issue(1'b1, 1'b0, 32'd20, 32'd6);
        check("b2b_init", {div_init, mult_init, bus.busy}, 3'b101);
        watch(40);
        check("b2b_done_at", done_at, 35);
        check("b2b_hilo", {hi_d, lo_d}, {32'd2, 32'd3});

        issue(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_hilo", {bus.hi, bus.lo}, 0);
        check("mid_rst_init", {div_init, mult_init}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'd9, 32'd3);
        watch(40);
        check("post_rst_done_at", done_at, 35);
        check("post_rst_hilo", {hi_d, lo_d}, {32'd0, 32'd3});

`ifdef MULDIV_SIGNED_EN
        issue(1'b1, 1'b1, -32'sd7, 32'd2);
        check("sdiv_mag", {unit_a, unit_b}, {32'd7, 32'd2});
        watch(40);
        check("sdiv_hilo", {hi_d, lo_d}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(1'b0, 1'b1, -32'sd3, 32'd4);
        watch(40);
        check("smul_hilo", {hi_d, lo_d}, 64'hFFFF_FFFF_FFFF_FFF4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
